// File: rtl/adc_capture_ctrl_if.sv
// adc_capture_ctrl_if
//   AXI-Stream bundle carrying captured words from adc_capture_ctrl to the
//   PL-to-PS serializer.
//   master: drives tdata/tvalid/tlast, samples tready (capture controller)
//   slave : samples tdata/tvalid/tlast, drives tready (serializer / bench)
interface adc_capture_ctrl_if #(
  parameter int DATA_W = 128
) ();
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl
//   Arms on a rising edge of arm, waits for a rising trigger edge, then
//   captures capture_len slots of the free-running ADC stream into a 16-deep
//   FIFO which is presented as an AXI-Stream master (tlast on final slot).
//   Optional macro ADC_CAPTURE_DECIM_EN adds a decim[7:0] input so that only
//   every (decim+1)-th valid ADC word inside the window is a capture slot.
// Ports:
//   clk, rst            clock, async active-high reset
//   s_adc_tdata/tvalid  ADC stream (never stalls)
//   arm, trigger        level inputs, rising edges used
//   flush               synchronous abort + FIFO clear while high
//   capture_len         slots per capture, sampled on arm
//   decim               (ADC_CAPTURE_DECIM_EN only) decimation, sampled on arm
//   m_axis              AXI-Stream master (tdata/tvalid/tlast out, tready in)
//   busy                state != IDLE
//   done                one-cycle pulse when a capture has fully drained
//   overflow            sticky, a slot was dropped because the FIFO was full
//   words_captured      slots consumed in the current/last capture
module adc_capture_ctrl #(
  parameter int DATA_W  = 128,
  parameter int LEN_W   = 16,
  parameter int FIFO_AW = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   s_adc_tdata,
  input  logic                s_adc_tvalid,
  input  logic                arm,
  input  logic                flush,
  input  logic                trigger,
  input  logic [LEN_W-1:0]    capture_len,
`ifdef ADC_CAPTURE_DECIM_EN
  input  logic [7:0]          decim,
`endif
  adc_capture_ctrl_if.master  m_axis,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [LEN_W-1:0]    words_captured
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int PW    = FIFO_AW + 1;

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DRAIN} state_t;

  state_t            r_state;
  logic              r_arm_q, r_trig_q;
  logic [LEN_W-1:0]  r_len, r_words;
  logic              r_done, r_overflow;

  // FIFO storage; tlast rides in the top bit.
  logic [DATA_W:0]   r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_last, r_out_vld;

  logic              w_arm_rise, w_trig_rise;
  logic              w_win, w_slot, w_tlast, w_last_slot;
  logic              w_push, w_pop, w_drop, w_full, w_empty;
  logic [PW-1:0]     w_count, w_wr_nxt, w_rd_nxt;
  logic [DATA_W:0]   w_wdata, w_head_nxt;

  assign w_arm_rise  = arm & ~r_arm_q;
  assign w_trig_rise = trigger & ~r_trig_q;

  // A valid ADC word inside the capture window. The trigger cycle itself is
  // part of the window, so the word beside the trigger edge is slot 0.
  assign w_win = ~flush & s_adc_tvalid &
                 ((r_state == CAPTURE) | ((r_state == ARMED) & w_trig_rise));

`ifdef ADC_CAPTURE_DECIM_EN
  logic [7:0] r_decim, r_phase, w_phase;
  // Phase is treated as 0 on the trigger cycle so the first word is a slot.
  assign w_phase = (r_state == CAPTURE) ? r_phase : 8'd0;
  assign w_slot  = w_win & (w_phase == 8'd0);
`else
  assign w_slot  = w_win;
`endif

  assign w_tlast     = (r_words == r_len - LEN_W'(1));
  assign w_last_slot = w_slot & w_tlast;
  assign w_wdata     = {w_tlast, s_adc_tdata};

  // The output register always mirrors the FIFO head, so the count covers
  // everything held including the word on the bus; full means 16 words total.
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_count == PW'(DEPTH));
  assign w_empty = (w_count == '0);
  assign w_pop   = r_out_vld & m_axis.tready;
  // A full FIFO still accepts a write when a beat leaves in the same cycle.
  assign w_push  = w_slot & (~w_full | w_pop);
  assign w_drop  = w_slot & w_full & ~w_pop;

  assign w_wr_nxt = r_wr_ptr + PW'(w_push);
  assign w_rd_nxt = r_rd_ptr + PW'(w_pop);
  // If the new head is the entry being written now, bypass the memory.
  assign w_head_nxt = (w_push && (r_wr_ptr == w_rd_nxt)) ? w_wdata
                                                         : r_mem[w_rd_nxt[FIFO_AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[FIFO_AW-1:0]] <= w_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_out_vld  <= 1'b0;
      r_out_last <= 1'b0;
      r_out_data <= '0;
    end else if (flush) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_out_vld <= 1'b0;
    end else begin
      r_wr_ptr  <= w_wr_nxt;
      r_rd_ptr  <= w_rd_nxt;
      r_out_vld <= (w_wr_nxt != w_rd_nxt);
      // Head is unchanged while stalled, so data/last stay stable.
      if (w_wr_nxt != w_rd_nxt) {r_out_last, r_out_data} <= w_head_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_arm_q    <= 1'b0;
      r_trig_q   <= 1'b0;
      r_len      <= '0;
      r_words    <= '0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
`ifdef ADC_CAPTURE_DECIM_EN
      r_decim    <= '0;
      r_phase    <= '0;
`endif
    end else begin
      r_arm_q  <= arm;
      r_trig_q <= trigger;
      r_done   <= 1'b0;
      if (flush) begin
        r_state    <= IDLE;
        r_words    <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (w_slot) r_words    <= r_words + LEN_W'(1);
        if (w_drop) r_overflow <= 1'b1;
`ifdef ADC_CAPTURE_DECIM_EN
        if (r_state != CAPTURE) r_phase <= '0;
        if (w_win) r_phase <= (w_phase == r_decim) ? 8'd0 : w_phase + 8'd1;
`endif
        case (r_state)
          IDLE: begin
            if (w_arm_rise && capture_len != '0) begin
              r_len      <= capture_len;
              r_words    <= '0;
              r_overflow <= 1'b0;
`ifdef ADC_CAPTURE_DECIM_EN
              r_decim    <= decim;
`endif
              r_state    <= ARMED;
            end
          end
          ARMED: begin
            if (w_trig_rise) r_state <= w_last_slot ? DRAIN : CAPTURE;
          end
          CAPTURE: begin
            if (w_last_slot) r_state <= DRAIN;
          end
          DRAIN: begin
            if (w_empty) begin
              r_done  <= 1'b1;
              r_state <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign busy           = (r_state != IDLE);
  assign done           = r_done;
  assign overflow       = r_overflow;
  assign words_captured = r_words;
  assign m_axis.tdata   = r_out_data;
  assign m_axis.tvalid  = r_out_vld;
  assign m_axis.tlast   = r_out_last;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
module tb_adc_capture_ctrl;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] s_adc_tdata = '0;
  logic         s_adc_tvalid = 1'b0;
  logic         arm = 1'b0, flush = 1'b0, trigger = 1'b0;
  logic [15:0]  capture_len = '0;
  logic         busy, done, overflow;
  logic [15:0]  words_captured;
`ifdef ADC_CAPTURE_DECIM_EN
  logic [7:0]   decim = '0;
`endif

  adc_capture_ctrl_if #(.DATA_W(128)) axis ();

  adc_capture_ctrl dut (
    .clk(clk), .rst(rst),
    .s_adc_tdata(s_adc_tdata), .s_adc_tvalid(s_adc_tvalid),
    .arm(arm), .flush(flush), .trigger(trigger), .capture_len(capture_len),
`ifdef ADC_CAPTURE_DECIM_EN
    .decim(decim),
`endif
    .m_axis(axis),
    .busy(busy), .done(done), .overflow(overflow), .words_captured(words_captured)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0, n_done = 0;
  logic [128:0] q[$];
  logic [128:0] e[$];

  // Beats and done pulses observed on the falling edge, away from the update.
  always @(negedge clk) begin
    if (!rst) begin
      if (axis.tvalid && axis.tready) q.push_back({axis.tlast, axis.tdata});
      if (done) n_done++;
    end
  end

  task automatic chk(input string tag, input logic [128:0] got, input logic [128:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    s_adc_tvalid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [128:0] bt(input logic last, input int d);
    return {last, 128'(d)};
  endfunction

  task automatic chk_q(input string tag);
    chk({tag, "_n"}, 129'(q.size()), 129'(e.size()));
    for (int i = 0; i < e.size(); i++)
      chk(tag, (i < q.size()) ? q[i] : '1, e[i]);
  endtask

  task automatic start(input int len);
    q = {}; e = {}; n_done = 0;
    capture_len = 16'(len);
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  // ADC word d on this cycle; trig drives the trigger level.
  task automatic adc(input logic v, input int d, input logic trig);
    s_adc_tvalid = v; s_adc_tdata = 128'(d); trigger = trig; tick();
  endtask

  initial begin
    axis.tready = 1'b1;
    tick(); tick();
    chk("rst_tvalid", 129'(axis.tvalid), 0);
    chk("rst_tlast", 129'(axis.tlast), 0);
    chk("rst_tdata", 129'(axis.tdata), 0);
    chk("rst_busy", 129'(busy), 0);
    chk("rst_done", 129'(done), 0);
    chk("rst_ovf", 129'(overflow), 0);
    chk("rst_words", 129'(words_captured), 0);
    rst = 1'b0; tick();

    // Basic capture
    start(4);
    chk("basic_busy", 129'(busy), 1);
    for (int k = 1; k <= 6; k++) adc(1'b1, k, 1'b1);
    idle(8);
    trigger = 1'b0;
    for (int k = 1; k <= 4; k++) e.push_back(bt(k == 4, k));
    chk_q("basic_q");
    chk("basic_done", 129'(n_done), 1);
    chk("basic_ovf", 129'(overflow), 0);
    chk("basic_words", 129'(words_captured), 4);
    chk("basic_idle", 129'(busy), 0);

    // Backpressure / overflow
    axis.tready = 1'b0;
    start(20);
    for (int k = 1; k <= 20; k++) adc(1'b1, k, 1'b1);
    idle(3);
    trigger = 1'b0;
    chk("ovf_flag", 129'(overflow), 1);
    chk("ovf_words", 129'(words_captured), 20);
    chk("ovf_busy", 129'(busy), 1);
    chk("ovf_head", {axis.tlast, axis.tdata}, bt(1'b0, 1));
    chk("ovf_nodone", 129'(n_done), 0);
    axis.tready = 1'b1;
    idle(24);
    for (int k = 1; k <= 16; k++) e.push_back(bt(1'b0, k));
    chk_q("ovf_q");
    chk("ovf_done", 129'(n_done), 1);

    // Gapped ADC valid
    start(3);
    adc(1'b1, 1, 1'b1); adc(1'b0, 2, 1'b1); adc(1'b1, 3, 1'b1);
    adc(1'b0, 4, 1'b1); adc(1'b1, 5, 1'b1);
    idle(6);
    trigger = 1'b0;
    e.push_back(bt(0, 1)); e.push_back(bt(0, 3)); e.push_back(bt(1, 5));
    chk_q("gap_q");
    chk("gap_done", 129'(n_done), 1);

    // Flush mid-capture
    axis.tready = 1'b0;
    start(10);
    for (int k = 1; k <= 5; k++) adc(1'b1, k, 1'b1);
    chk("fl_pre_vld", 129'(axis.tvalid), 1);
    s_adc_tvalid = 1'b0; flush = 1'b1; tick();
    chk("fl_vld", 129'(axis.tvalid), 0);
    chk("fl_busy", 129'(busy), 0);
    chk("fl_words", 129'(words_captured), 0);
    flush = 1'b0; trigger = 1'b0;
    axis.tready = 1'b1;
    idle(4);
    chk_q("fl_q");
    chk("fl_nodone", 129'(n_done), 0);
    start(2);
    adc(1'b1, 'hA, 1'b1); adc(1'b1, 'hB, 1'b1);
    idle(5);
    trigger = 1'b0;
    e.push_back(bt(0, 'hA)); e.push_back(bt(1, 'hB));
    chk_q("fl_after_q");
    chk("fl_after_done", 129'(n_done), 1);

    // arm with length 0 is ignored
    start(0);
    chk("len0_busy", 129'(busy), 0);

    // Trigger already high before arm: needs a fresh edge
    trigger = 1'b1; tick(); tick();
    start(2);
    for (int k = 1; k <= 3; k++) adc(1'b1, k, 1'b1);
    chk("hold_words", 129'(words_captured), 0);
    chk("hold_busy", 129'(busy), 1);
    adc(1'b0, 0, 1'b0);
    adc(1'b1, 'h21, 1'b1); adc(1'b1, 'h22, 1'b1);
    idle(5);
    trigger = 1'b0;
    e.push_back(bt(0, 'h21)); e.push_back(bt(1, 'h22));
    chk_q("hold_q");

    // Async reset in CAPTURE
    start(5);
    adc(1'b1, 1, 1'b1); adc(1'b1, 2, 1'b1);
    chk("ar_pre_vld", 129'(axis.tvalid), 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_vld", 129'(axis.tvalid), 0);
    chk("ar_data", 129'(axis.tdata), 0);
    chk("ar_busy", 129'(busy), 0);
    chk("ar_words", 129'(words_captured), 0);
    s_adc_tvalid = 1'b0; trigger = 1'b0;
    tick(); rst = 1'b0; tick();

`ifdef ADC_CAPTURE_DECIM_EN
    decim = 8'd2;
    start(3);
    for (int k = 1; k <= 9; k++) adc(1'b1, k, 1'b1);
    idle(6);
    trigger = 1'b0;
    e.push_back(bt(0, 1)); e.push_back(bt(0, 4)); e.push_back(bt(1, 7));
    chk_q("dec_q");
    chk("dec_done", 129'(n_done), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
- Upstream neighbour of the PL-to-PS serializer.
- Takes the free-running 128-bit ADC sample stream (8 x 16-bit samples per beat) from the data converter. On an armed trigger edge it captures a programmed number of 128-bit words into a small internal FIFO.
- Presents the FIFO as a 128-bit AXI-Stream master with tlast on the final captured word. Overflow and status are reported to the PS through GPIO.

Parameters:
- DATA_W, 128, ADC stream and output word width in bits.
- LEN_W, 16, width of capture_len and the word counters.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW = 16 words.

Ports:
- clk  in  1  single capture/system clock.
- rst  in  1  asynchronous, active-high reset.
- s_adc_tdata  in  DATA_W  ADC sample word (no tready; source never stalls).
- s_adc_tvalid  in  1  ADC word valid.
- arm  in  1  level; a rising edge arms a capture.
- flush  in  1  level; synchronous abort and FIFO clear while high.
- trigger  in  1  capture trigger; rising edge is used.
- capture_len  in  LEN_W  number of words to capture; sampled on arm.
- m_axis_tdata  out  DATA_W  captured word to the serializer.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  marks the final word of a capture.
- busy  out  1  high in ARMED, CAPTURE or DRAIN.
- done  out  1  one-cycle pulse when a capture fully drains.
- overflow  out  1  sticky; set when a captured word is dropped because the FIFO is full.
- words_captured  out  LEN_W  count of capture slots consumed in the current or last capture.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; FIFO empty.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
  - busy=0, done=0, overflow=0, words_captured=0.
  - Edge-detect registers for arm and trigger cleared to 0.
- Edge detect: arm_rise = arm & ~arm_q; trig_rise = trigger & ~trig_q. Both registered every cycle.
- flush has highest priority, every cycle while high:
  - state→IDLE; FIFO pointers cleared.
  - overflow=0, words_captured=0, done=0.
  - m_axis_tvalid=0 from the next cycle.
- IDLE:
  - On arm_rise with capture_len!=0: latch len_q=capture_len; words_captured=0; overflow=0; →ARMED.
  - arm_rise with capture_len==0 is ignored.
- ARMED: on trig_rise →CAPTURE. If s_adc_tvalid is high in that same cycle, that word is the first captured slot.
- CAPTURE: each cycle with s_adc_tvalid=1 is one capture slot.
  - words_captured increments on every slot.
  - The word is written to the FIFO with tlast = (words_captured == len_q-1).
  - If the FIFO is full, the word is dropped and overflow is set (sticky); the slot is still counted, so the capture window length is fixed.
  - On the slot with words_captured == len_q-1 →DRAIN.
- DRAIN: when the FIFO is empty and no output beat is pending: pulse done=1 for one cycle; →IDLE.
- If the final word was dropped, no tlast is emitted; overflow=1 tells the PS the frame is invalid.
- FIFO:
  - 16 x (DATA_W+1) storage; tlast is stored as the extra bit.
  - Registered output: a word written in cycle N is visible on m_axis_tvalid no earlier than N+1.
  - Output beat completes when tvalid & tready.
  - Simultaneous read and write when full is allowed only if a read also occurs that cycle; the write is accepted and nothing is dropped.
  - m_axis_tdata and m_axis_tlast hold stable while tvalid=1 and tready=0.
- arm_rise or trig_rise outside the states above is ignored. Re-arming requires a return to IDLE.
- busy is combinational from state; done and overflow are registered.

Optional Feature:
- Macro: ADC_CAPTURE_DECIM_EN.
- Defined:
  - Adds input port decim [7:0], sampled on arm.
  - In CAPTURE, only every (decim+1)-th valid ADC word is a capture slot; the first valid word after the trigger is always a slot.
  - A phase counter resets on entry to CAPTURE; decim=0 keeps every word.
- Undefined: no decim port; every valid word is a slot.

Test Plan:
- Basic capture: capture_len=4, arm pulse, trigger edge, ADC words 0x..01–0x..06 continuous, m_axis_tready=1 → exactly words 1–4 out, tlast on word 4, done pulse after it drains, overflow=0, words_captured=4.
- Backpressure/overflow: capture_len=20, m_axis_tready=0 throughout capture → 16 words held in the FIFO, slots 17–20 dropped, overflow=1, no tlast; releasing tready drains 16 words, then done.
- Gapped ADC valid: capture_len=3, s_adc_tvalid toggling 1,0,1,0,1 → 3 words captured with gaps ignored; tlast on the third.
- Flush mid-capture: capture_len=10, flush asserted after 5 slots → state IDLE, m_axis_tvalid=0 next cycle, FIFO empty, no done pulse; a subsequent arm/trigger capture works normally.
- Edge cases: arm with capture_len=0 → stays IDLE, busy=0. Trigger held high before arm → no capture until trigger falls and rises again. Async rst asserted in CAPTURE → all outputs at reset values immediately.
- ADC_CAPTURE_DECIM_EN with decim=2, capture_len=3, 9 continuous ADC words 1–9 → output words 1,4,7; tlast on 7.
